// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between the instruction
// fetch port and the data port, granting one access at a time.
//
// Ports:
//   CLK, nRST            clock (rising edge), synchronous active-low reset
//   iREN/iaddr           instruction read request, held until iwait=0
//   iload/iwait          instruction data / active-low completion
//   dREN/dWEN            data read / write request, held until dwait=0
//   daddr/dstore         data address / write data
//   dload/dwait          data read data / active-low completion
//   ramREN/ramWEN        RAM read / write enable
//   ramaddr/ramstore     RAM address / write data
//   ramload/ram_ready    RAM read data / access completes this cycle
//   igrant_cnt           completed instruction accesses (perf build)
//   dgrant_cnt           completed data accesses (perf build)
//
// Optional feature macro: MEMORY_ARBITER_PERF_EN adds the two
// 32-bit completion counters.
module memory_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
`ifdef MEMORY_ARBITER_PERF_EN
  ,
  output logic [31:0]       igrant_cnt,
  output logic [31:0]       dgrant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } state_t;

  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] starve_cnt;
  logic          dreq;
  logic          starved;
  logic          idone;
  logic          ddone;

  assign dreq    = dREN | dWEN;
  assign starved = iREN && (STARVE_LIMIT != 0)
                   && (starve_cnt == LIM);

  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= next_state;
      if (!iREN || idone)
        starve_cnt <= '0;
      else if (ddone && starve_cnt != LIM)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Outputs are held idle while nRST is low so an abandoned access
  // never shows an enable or a wait pulse during reset.
  always_comb begin
    next_state = state;
    iwait      = 1'b1;
    dwait      = 1'b1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    idone      = 1'b0;
    ddone      = 1'b0;
    if (nRST) begin
      unique case (state)
        IDLE: begin
          if (dreq && !starved)
            next_state = DACC;
          else if (iREN)
            next_state = IACC;
        end
        IACC: begin
          if (!iREN) begin
            next_state = IDLE;
          end else begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (ram_ready) begin
              iwait      = 1'b0;
              idone      = 1'b1;
              next_state = IDLE;
            end
          end
        end
        DACC: begin
          if (!dreq) begin
            next_state = IDLE;
          end else begin
            // read+write together is serviced as a write
            ramWEN   = dWEN;
            ramREN   = ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (ram_ready) begin
              dwait      = 1'b0;
              ddone      = 1'b1;
              next_state = IDLE;
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

`ifdef MEMORY_ARBITER_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      igrant_cnt <= '0;
      dgrant_cnt <= '0;
    end else begin
      if (idone)
        igrant_cnt <= igrant_cnt + 32'd1;
      if (ddone)
        dgrant_cnt <= dgrant_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic,
// compared against a RAM-ownership reference model.
module tb_memory_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  localparam int NONE = 0;
  localparam int INS  = 1;
  localparam int DAT  = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          iREN, dREN, dWEN, ram_ready;
  logic [AW-1:0] iaddr, daddr, ramaddr;
  logic [DW-1:0] dstore, ramload, iload, dload, ramstore;
  logic          iwait, dwait, ramREN, ramWEN;
`ifdef MEMORY_ARBITER_PERF_EN
  logic [31:0]   igrant_cnt, dgrant_cnt;
`endif

  always #5 CLK = ~CLK;

  memory_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
`ifdef MEMORY_ARBITER_PERF_EN
    ,
    .igrant_cnt(igrant_cnt),
    .dgrant_cnt(dgrant_cnt)
`endif
  );

  int    nvec = 0;
  int    nbad = 0;
  int    owner = NONE;
  int    starve = 0;
  int    icnt = 0;
  int    dcnt = 0;
  bit    last_idone, last_ddone;
  string order;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict who owns the RAM from the current inputs,
  // compare at the falling edge, then advance the model.
  task automatic cycle();
    bit e_ren, e_wen, e_iw, e_dw, dq, strv;
    int nxt;
    @(negedge CLK);
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
    nxt   = owner;
    dq    = dREN | dWEN;
    strv  = iREN && LIM != 0 && starve == LIM;
    if (!nRST) begin
      nxt = NONE;
    end else if (owner == NONE) begin
      if (dq && !strv) nxt = DAT;
      else if (iREN)   nxt = INS;
    end else if (owner == INS) begin
      if (!iREN) nxt = NONE;
      else begin
        e_ren = 1;
        if (ram_ready) begin e_iw = 0; nxt = NONE; end
      end
    end else begin
      if (!dq) nxt = NONE;
      else begin
        e_wen = dWEN;
        e_ren = !dWEN;
        if (ram_ready) begin e_dw = 0; nxt = NONE; end
      end
    end
    chk("iwait", iwait, e_iw);
    chk("dwait", dwait, e_dw);
    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    if (e_ren || e_wen)
      chk("ramaddr", ramaddr,
          owner == INS ? iaddr : daddr);
    if (e_wen) chk("ramstore", ramstore, dstore);
    if (!nRST) begin
      chk("rst_addr", ramaddr, 0);
      chk("rst_store", ramstore, 0);
    end
    if (!e_iw) chk("iload", iload, ramload);
    if (!e_dw) chk("dload", dload, ramload);
`ifdef MEMORY_ARBITER_PERF_EN
    chk("igrant_cnt", igrant_cnt, icnt);
    chk("dgrant_cnt", dgrant_cnt, dcnt);
`endif
    last_idone = !e_iw;
    last_ddone = !e_dw;
    if (!nRST) begin
      starve = 0; icnt = 0; dcnt = 0;
    end else begin
      if (!e_iw) begin icnt++; order = {order, "I"}; end
      if (!e_dw) begin dcnt++; order = {order, "D"}; end
      if (!iREN || !e_iw) starve = 0;
      else if (!e_dw)
        starve = (starve + 1 > LIM) ? LIM : starve + 1;
    end
    owner = nxt;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
  endtask

  initial begin
    bit ion, don;
    int dleft;
    nRST = 0; idle_inputs();
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;

    // reset held with requests pending
    iREN = 1; dREN = 1;
    repeat (2) cycle();
    nRST = 1; idle_inputs();
    cycle();

    // single instruction fetch
    iREN = 1; iaddr = 32'h40; ramload = 32'h8C220004;
    cycle();
    chk("t2_grant_wait", iwait, 1);
    ram_ready = 1;
    cycle();
    chk("t2_done", last_idone, 1);
    idle_inputs();
    cycle();

    // simultaneous instruction read and data write
    order = "";
    iREN = 1; iaddr = 32'h80;
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    ram_ready = 1;
    for (int k = 0; k < 20 && order.len() < 2; k++) begin
      cycle();
      if (last_idone) iREN = 0;
      if (last_ddone) dWEN = 0;
    end
    chk("t3_order", order == "DI", 1);
    idle_inputs();
    cycle();

    // starvation limit with six back-to-back data reads
    order = "";
    iREN = 1; dREN = 1; ram_ready = 1; dleft = 6;
    for (int k = 0; k < 60 && (dleft > 0 || iREN); k++) begin
      daddr = $urandom; ramload = $urandom;
      cycle();
      if (last_ddone) dleft--;
      if (dleft == 0) dREN = 0;
      if (last_idone) iREN = 0;
    end
    chk("t4_order", order == "DDDDIDD", 1);
    idle_inputs();
    cycle();

    // data request withdrawn before the RAM answers
    dREN = 1; daddr = 32'h200;
    cycle();
    dREN = 0;
    cycle();
    chk("t5_owner", owner, NONE);
    cycle();

    // randomized traffic with occasional drops and resets
    ion = 0; don = 0;
    for (int k = 0; k < 2000; k++) begin
      nRST = ($urandom % 150) != 0;
      if (!ion && $urandom % 3 == 0) begin
        ion = 1; iREN = 1; iaddr = $urandom;
      end else if (ion && $urandom % 25 == 0) begin
        ion = 0; iREN = 0;
      end
      if (!don && $urandom % 3 == 0) begin
        int kind;
        kind = $urandom % 3;
        don = 1;
        dREN = kind != 1;
        dWEN = kind != 0;
        daddr = $urandom; dstore = $urandom;
      end else if (don && $urandom % 25 == 0) begin
        don = 0; dREN = 0; dWEN = 0;
      end
      ram_ready = $urandom % 2;
      ramload = $urandom;
      cycle();
      if (last_idone) begin ion = 0; iREN = 0; end
      if (last_ddone) begin
        don = 0; dREN = 0; dWEN = 0;
      end
    end
    nRST = 1; idle_inputs();
    cycle();

`ifdef MEMORY_ARBITER_PERF_EN
    // completion counters: 3 fetches, 5 data accesses
    nRST = 0; cycle(); nRST = 1;
    chk("t6_rst_i", igrant_cnt, 0);
    chk("t6_rst_d", dgrant_cnt, 0);
    ram_ready = 1;
    for (int n = 0; n < 8; n++) begin
      if (n < 3) iREN = 1; else dREN = 1;
      for (int k = 0; k < 10 && (iREN || dREN); k++) begin
        cycle();
        if (last_idone) iREN = 0;
        if (last_ddone) dREN = 0;
      end
    end
    cycle();
    chk("t6_icnt", igrant_cnt, 3);
    chk("t6_dcnt", dgrant_cnt, 5);
    nRST = 0; cycle(); nRST = 1;
    chk("t6_clr_i", igrant_cnt, 0);
    chk("t6_clr_d", dgrant_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
